// File: rtl/dcache_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter_pkg
// Shared types for the D$ request-port arbiter:
//   - dcache_req_i_t : requester -> cache request struct
//   - dcache_req_o_t : cache -> requester grant / read response struct
//   - DC_PORT_*      : requester index assignment (store buffer, load, AMO)
//   - arb_state_e    : arbiter lock state
// -----------------------------------------------------------------------------
package dcache_port_arbiter_pkg;

  localparam int unsigned DC_PORT_STB = 0;
  localparam int unsigned DC_PORT_LD  = 1;
  localparam int unsigned DC_PORT_AMO = 2;

  localparam int unsigned DC_INDEX_W = 12;
  localparam int unsigned DC_TAG_W   = 20;
  localparam int unsigned DC_DATA_W  = 64;

  typedef struct packed {
    logic [DC_INDEX_W-1:0] address_index;
    logic [DC_TAG_W-1:0]   address_tag;
    logic [DC_DATA_W-1:0]  data_wdata;
    logic                  data_req;
    logic                  data_we;
    logic [7:0]            data_be;
    logic [1:0]            data_size;
    logic                  kill_req;
    logic                  tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic                 data_gnt;
    logic                 data_rvalid;
    logic [DC_DATA_W-1:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // A read cannot be accepted while every response slot is already claimed.
  function automatic logic is_blocked_read(input dcache_req_i_t req, input logic fifo_full);
    return !req.data_we && fifo_full;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter_if
// Bundles the requester-side and cache-side buses of the arbiter.
//   req_ports_i  : NUM_PORTS requests into the arbiter
//   req_ports_o  : NUM_PORTS grant / read-response returns
//   dcache_req_o : selected request towards the D$
//   dcache_req_i : D$ grant and read response
// Modports: master = arbiter side, slave = requesters + cache side.
// -----------------------------------------------------------------------------
interface dcache_port_arbiter_if
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3
) ();

  dcache_req_i_t [NUM_PORTS-1:0] req_ports_i;
  dcache_req_o_t [NUM_PORTS-1:0] req_ports_o;
  dcache_req_i_t                 dcache_req_o;
  dcache_req_o_t                 dcache_req_i;

  modport master (
    input  req_ports_i,
    output req_ports_o,
    output dcache_req_o,
    input  dcache_req_i
  );

  modport slave (
    output req_ports_i,
    input  req_ports_o,
    input  dcache_req_o,
    output dcache_req_i
  );

endinterface

// File: rtl/dcache_port_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// dcache_id_fifo
// In-order FIFO of requester indices, one entry per read in flight.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_id  : enqueue a requester index (ignored when full)
//   i_pop         : dequeue the head (ignored when empty)
//   o_head        : index at the head
//   o_full/o_empty/o_count : registered occupancy
// DEPTH must be a power of 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module dcache_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_push,
  input  logic [ID_W-1:0]          i_id,
  input  logic                     i_pop,
  output logic [ID_W-1:0]          o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while r_count says valid.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_id;
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
// Shares one D$ request port among NUM_PORTS requesters (0 = store buffer,
// 1 = load unit, 2 = AMO unit). An eligible requester is chosen combinationally
// and, if the cache does not grant at once, held (LOCKED) until it does.
// Granted reads record their requester index in an in-order FIFO so each
// data_rvalid is routed back to the requester that issued the read.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   io_bus  : requester and cache buses (dcache_port_arbiter_if.master)
//   busy_o  : lock held or any read outstanding
// Build options:
//   DCACHE_ARB_FIXED_PRIO_EN : fixed priority, lowest index wins (no rr_q)
//   DCACHE_ARB_ASSERT_ON     : enable protocol assertions
// -----------------------------------------------------------------------------
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  dcache_port_arbiter_if.master  io_bus,
  output logic                   busy_o
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e          r_state;
  arb_state_e          w_state_d;
  logic [PORT_W-1:0]   r_sel;
  logic [PORT_W-1:0]   w_sel_d;

  logic [NUM_PORTS-1:0] w_elig;
  logic [PORT_W-1:0]    w_pick;
  logic                 w_pick_vld;
  logic [PORT_W-1:0]    w_cur_idx;
  logic                 w_cur_vld;
  dcache_req_i_t        w_cur_req;
  logic                 w_gnt;

  logic                 w_fifo_push;
  logic                 w_fifo_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [PORT_W-1:0]    w_fifo_head;
  logic [CNT_W-1:0]     w_fifo_count;

  // Eligibility uses the registered FIFO occupancy, so a pop in this cycle
  // does not unmask reads until the next cycle.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_elig[PORT_W'(i)] = io_bus.req_ports_i[PORT_W'(i)].data_req &&
                           !is_blocked_read(io_bus.req_ports_i[PORT_W'(i)], w_fifo_full);
    end
  end

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int unsigned i = NUM_PORTS; i > 0; i--) begin
      if (w_elig[PORT_W'(i - 1)]) begin
        w_pick     = PORT_W'(i - 1);
        w_pick_vld = 1'b1;
      end
    end
  end
`else
  logic [PORT_W-1:0] r_rr;

  // Search order is rr_q+1, rr_q+2, ... rr_q (mod NUM_PORTS); scanning the
  // offsets downwards lets the nearest eligible requester win.
  always_comb begin : p_rr_pick
    logic [31:0] idx;
    idx        = '0;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int unsigned k = NUM_PORTS; k > 0; k--) begin
      idx = (32'(r_rr) + k) % NUM_PORTS;
      if (w_elig[PORT_W'(idx)]) begin
        w_pick     = PORT_W'(idx);
        w_pick_vld = 1'b1;
      end
    end
  end

  // Port 0 gets first priority out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= PORT_W'(NUM_PORTS - 1);
    end else if (w_gnt) begin
      r_rr <= w_cur_idx;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_cur_idx = '0;
    w_cur_vld = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        w_cur_idx = w_pick;
        w_cur_vld = w_pick_vld;
      end
      ARB_LOCKED: begin
        w_cur_idx = r_sel;
        w_cur_vld = 1'b1;
      end
      default: ;
    endcase

    w_cur_req = w_cur_vld ? io_bus.req_ports_i[w_cur_idx] : '0;
    // A cache grant only counts while the forwarded request is actually live.
    w_gnt     = w_cur_vld && w_cur_req.data_req && io_bus.dcache_req_i.data_gnt;

    case (r_state)
      ARB_IDLE: begin
        if (w_pick_vld && !w_gnt) begin
          w_state_d = ARB_LOCKED;
          w_sel_d   = w_pick;
        end
      end
      ARB_LOCKED: begin
        // Dropping data_req while locked is a requester protocol violation;
        // release the lock without touching rr_q or the FIFO.
        if (w_gnt || !w_cur_req.data_req) begin
          w_state_d = ARB_IDLE;
        end
      end
      default: w_state_d = ARB_IDLE;
    endcase
  end

  assign io_bus.dcache_req_o = w_cur_req;

  assign w_fifo_push = w_gnt && !w_cur_req.data_we;
  assign w_fifo_pop  = io_bus.dcache_req_i.data_rvalid && !w_fifo_empty;

  always_comb begin
    io_bus.req_ports_o = '0;
    if (w_gnt) begin
      io_bus.req_ports_o[w_cur_idx].data_gnt = 1'b1;
    end
    if (w_fifo_pop) begin
      io_bus.req_ports_o[w_fifo_head].data_rvalid = 1'b1;
      io_bus.req_ports_o[w_fifo_head].data_rdata  = io_bus.dcache_req_i.data_rdata;
    end
  end

  assign busy_o = (r_state == ARB_LOCKED) || (w_fifo_count != '0);

  dcache_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (PORT_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_fifo_push),
    .i_id    (w_cur_idx),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

`ifdef DCACHE_ARB_ASSERT_ON
  a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ARB_LOCKED) |-> io_bus.req_ports_i[r_sel].data_req);

  a_rvalid_has_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
    io_bus.dcache_req_i.data_rvalid |-> !w_fifo_empty);
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int unsigned NP   = 3;
  localparam int unsigned MAXO = 4;
  localparam int unsigned PW   = 2;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dcache_port_arbiter_if #(.NUM_PORTS(NP)) bus_if ();

  dcache_port_arbiter #(
    .NUM_PORTS       (NP),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io_bus (bus_if),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, outputs are sampled at posedge+4.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    bus_if.req_ports_i  = '0;
    bus_if.dcache_req_i = '0;
  endtask

  function automatic dcache_req_i_t mk_req(input logic we);
    dcache_req_i_t r;
    r.address_index = DC_INDEX_W'($urandom);
    r.address_tag   = DC_TAG_W'($urandom);
    r.data_wdata    = {$urandom, $urandom};
    r.data_req      = 1'b1;
    r.data_we       = we;
    r.data_be       = 8'($urandom);
    r.data_size     = 2'($urandom);
    r.kill_req      = 1'($urandom);
    r.tag_valid     = 1'($urandom);
    return r;
  endfunction

  function automatic logic [NP-1:0] gnt_vec();
    logic [NP-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[PW'(i)] = bus_if.req_ports_o[PW'(i)].data_gnt;
    return v;
  endfunction

  function automatic logic [NP-1:0] onehot(input int unsigned p);
    logic [NP-1:0] v;
    v = '0;
    v[PW'(p)] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    n_checks++;
    if (bus_if.dcache_req_o.data_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dreq: got %b expected 0", bus_if.dcache_req_o.data_req);
    end
    n_checks++;
    if (bus_if.req_ports_o !== '0) begin
      n_fail++;
      $display("FAIL reset_ports_o: got %h expected 0", bus_if.req_ports_o);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_rr_order();
    dcache_req_i_t r [NP];
    int unsigned e;
    for (int p = 0; p < NP; p++) begin
      r[p] = mk_req(1'b1);
      bus_if.req_ports_i[PW'(p)] = r[p];
    end
    bus_if.dcache_req_i.data_gnt = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      settle();
      e = FIXED_PRIO ? DC_PORT_STB : k % NP;
      n_checks++;
      if (gnt_vec() !== onehot(e)) begin
        n_fail++;
        $display("FAIL rr_order_gnt[%0d]: got %b expected %b", k, gnt_vec(), onehot(e));
      end
      n_checks++;
      if (bus_if.dcache_req_o !== r[e]) begin
        n_fail++;
        $display("FAIL rr_order_fwd[%0d]: got %h expected %h", k, bus_if.dcache_req_o, r[e]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_lock_hold();
    dcache_req_i_t s0, s1;
    s0 = mk_req(1'b1);
    s1 = mk_req(1'b1);
    bus_if.req_ports_i[PW'(DC_PORT_STB)] = s0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) bus_if.req_ports_i[PW'(DC_PORT_LD)] = s1;
      settle();
      n_checks++;
      if (bus_if.dcache_req_o !== s0) begin
        n_fail++;
        $display("FAIL lock_fwd[%0d]: got %h expected %h", c, bus_if.dcache_req_o, s0);
      end
      n_checks++;
      if (gnt_vec() !== 3'b000) begin
        n_fail++;
        $display("FAIL lock_nognt[%0d]: got %b expected 000", c, gnt_vec());
      end
      n_checks++;
      if (busy !== (c >= 2)) begin
        n_fail++;
        $display("FAIL lock_busy[%0d]: got %b expected %b", c, busy, (c >= 2));
      end
      next_cycle();
    end
    bus_if.dcache_req_i.data_gnt = 1'b1;
    settle();
    n_checks++;
    if (gnt_vec() !== 3'b001) begin
      n_fail++;
      $display("FAIL lock_gnt_c4: got %b expected 001", gnt_vec());
    end
    n_checks++;
    if (bus_if.dcache_req_o !== s0) begin
      n_fail++;
      $display("FAIL lock_fwd_c4: got %h expected %h", bus_if.dcache_req_o, s0);
    end
    next_cycle();
    bus_if.req_ports_i[PW'(DC_PORT_STB)] = '0;
    settle();
    n_checks++;
    if (gnt_vec() !== 3'b010) begin
      n_fail++;
      $display("FAIL lock_next_gnt: got %b expected 010", gnt_vec());
    end
    n_checks++;
    if (bus_if.dcache_req_o !== s1) begin
      n_fail++;
      $display("FAIL lock_next_fwd: got %h expected %h", bus_if.dcache_req_o, s1);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    int unsigned seq [4] = '{DC_PORT_LD, DC_PORT_AMO, DC_PORT_LD, DC_PORT_AMO};
    dcache_req_i_t w0;
    dcache_req_o_t [NP-1:0] exp_o;
    bus_if.dcache_req_i.data_gnt = 1'b1;
    foreach (seq[i]) begin
      bus_if.req_ports_i = '0;
      bus_if.req_ports_i[PW'(seq[i])] = mk_req(1'b0);
      settle();
      n_checks++;
      if (gnt_vec() !== onehot(seq[i])) begin
        n_fail++;
        $display("FAIL fill_gnt[%0d]: got %b expected %b", i, gnt_vec(), onehot(seq[i]));
      end
      next_cycle();
    end
    bus_if.req_ports_i = '0;
    bus_if.req_ports_i[PW'(DC_PORT_LD)] = mk_req(1'b0);
    settle();
    n_checks++;
    if (bus_if.dcache_req_o.data_req !== 1'b0 || gnt_vec() !== 3'b000) begin
      n_fail++;
      $display("FAIL full_read_masked: got dreq=%b gnt=%b expected dreq=0 gnt=000",
               bus_if.dcache_req_o.data_req, gnt_vec());
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_busy: got %b expected 1", busy);
    end
    next_cycle();
    w0 = mk_req(1'b1);
    bus_if.req_ports_i[PW'(DC_PORT_STB)] = w0;
    settle();
    n_checks++;
    if (gnt_vec() !== 3'b001 || bus_if.dcache_req_o !== w0) begin
      n_fail++;
      $display("FAIL full_write_gnt: got gnt=%b fwd=%h expected gnt=001 fwd=%h",
               gnt_vec(), bus_if.dcache_req_o, w0);
    end
    next_cycle();
    bus_if.req_ports_i[PW'(DC_PORT_STB)] = '0;
    bus_if.dcache_req_i.data_rvalid = 1'b1;
    bus_if.dcache_req_i.data_rdata  = 64'hDEAD;
    settle();
    exp_o = '0;
    exp_o[PW'(DC_PORT_LD)].data_rvalid = 1'b1;
    exp_o[PW'(DC_PORT_LD)].data_rdata  = 64'hDEAD;
    n_checks++;
    if (bus_if.req_ports_o !== exp_o) begin
      n_fail++;
      $display("FAIL full_pop_route: got %h expected %h", bus_if.req_ports_o, exp_o);
    end
    n_checks++;
    if (bus_if.dcache_req_o.data_req !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_still_masked: got %b expected 0", bus_if.dcache_req_o.data_req);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_same_cycle_push_pop();
    dcache_req_o_t [NP-1:0] exp_o;
    logic [63:0] rd;
    int unsigned heads [3] = '{DC_PORT_AMO, DC_PORT_AMO, DC_PORT_AMO};
    // Remaining ids: AMO, LD, AMO. Drop the head so count becomes 2.
    rd = {$urandom, $urandom};
    bus_if.dcache_req_i.data_rvalid = 1'b1;
    bus_if.dcache_req_i.data_rdata  = rd;
    settle();
    exp_o = '0;
    exp_o[PW'(heads[0])].data_rvalid = 1'b1;
    exp_o[PW'(heads[0])].data_rdata  = rd;
    n_checks++;
    if (bus_if.req_ports_o !== exp_o) begin
      n_fail++;
      $display("FAIL pp_first_pop: got %h expected %h", bus_if.req_ports_o, exp_o);
    end
    next_cycle();
    rd = {$urandom, $urandom};
    bus_if.dcache_req_i.data_rdata = rd;
    bus_if.dcache_req_i.data_gnt   = 1'b1;
    bus_if.req_ports_i[PW'(DC_PORT_AMO)] = mk_req(1'b0);
    settle();
    exp_o = '0;
    exp_o[PW'(DC_PORT_LD)].data_rvalid = 1'b1;
    exp_o[PW'(DC_PORT_LD)].data_rdata  = rd;
    exp_o[PW'(DC_PORT_AMO)].data_gnt   = 1'b1;
    n_checks++;
    if (bus_if.req_ports_o !== exp_o) begin
      n_fail++;
      $display("FAIL pp_same_cycle: got %h expected %h", bus_if.req_ports_o, exp_o);
    end
    next_cycle();
    bus_if.req_ports_i = '0;
    bus_if.dcache_req_i.data_gnt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      rd = {$urandom, $urandom};
      bus_if.dcache_req_i.data_rdata = rd;
      settle();
      exp_o = '0;
      if (i <= 2) begin
        exp_o[PW'(heads[i])].data_rvalid = 1'b1;
        exp_o[PW'(heads[i])].data_rdata  = rd;
      end
      n_checks++;
      if (bus_if.req_ports_o !== exp_o) begin
        n_fail++;
        $display("FAIL pp_drain[%0d]: got %h expected %h", i, bus_if.req_ports_o, exp_o);
      end
      n_checks++;
      if (busy !== (i <= 2)) begin
        n_fail++;
        $display("FAIL pp_drain_busy[%0d]: got %b expected %b", i, busy, (i <= 2));
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus_if.dcache_req_i.data_gnt = 1'b1;
    bus_if.req_ports_i[PW'(DC_PORT_LD)] = mk_req(1'b0);
    settle();
    n_checks++;
    if (gnt_vec() !== 3'b010) begin
      n_fail++;
      $display("FAIL rst_mid_gnt1: got %b expected 010", gnt_vec());
    end
    next_cycle();
    bus_if.req_ports_i = '0;
    bus_if.req_ports_i[PW'(DC_PORT_AMO)] = mk_req(1'b0);
    settle();
    n_checks++;
    if (gnt_vec() !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_mid_gnt2: got %b expected 100", gnt_vec());
    end
    next_cycle();
    idle_inputs();
    settle();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy_before: got %b expected 1", busy);
    end
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    bus_if.dcache_req_i.data_rvalid = 1'b1;
    bus_if.dcache_req_i.data_rdata  = {$urandom, $urandom};
    settle();
    n_checks++;
    if (bus_if.req_ports_o !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_rvalid_dropped: got %h expected 0", bus_if.req_ports_o);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_busy_after: got %b expected 0", busy);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Reference model: requesters hold their request until granted; the model
  // tracks held selection, last winner and the outstanding read ids as a queue.
  task automatic test_random();
    dcache_req_i_t drv [NP];
    bit pending [NP];
    bit m_locked = 1'b0;
    int unsigned m_sel = 0;
    int unsigned m_rr = NP - 1;
    int unsigned q [$];
    int unsigned idx, cur;
    bit cur_vld, granted, full, rv;
    logic gnt;
    logic [63:0] rd;
    dcache_req_i_t exp_d;
    dcache_req_o_t [NP-1:0] exp_o;
    bit exp_busy;
    for (int p = 0; p < NP; p++) begin
      pending[p] = 1'b0;
      drv[p] = '0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pending[p] && $urandom_range(0, 2) == 0) begin
          drv[p] = mk_req(1'($urandom_range(0, 1)));
          pending[p] = 1'b1;
        end
        bus_if.req_ports_i[PW'(p)] = pending[p] ? drv[p] : '0;
      end
      gnt = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 2) == 0);
      rd  = {$urandom, $urandom};
      bus_if.dcache_req_i.data_gnt    = gnt;
      bus_if.dcache_req_i.data_rvalid = rv;
      bus_if.dcache_req_i.data_rdata  = rd;
      settle();

      full = (q.size() >= MAXO);
      cur_vld = 1'b0;
      cur = 0;
      if (m_locked) begin
        cur = m_sel;
        cur_vld = 1'b1;
      end else begin
        for (int unsigned off = 1; off <= NP; off++) begin
          idx = FIXED_PRIO ? off - 1 : (m_rr + off) % NP;
          if (!cur_vld && pending[idx] && !(!drv[idx].data_we && full)) begin
            cur = idx;
            cur_vld = 1'b1;
          end
        end
      end
      exp_d = (cur_vld && pending[cur]) ? drv[cur] : '0;
      granted = cur_vld && pending[cur] && gnt;
      exp_o = '0;
      if (granted) exp_o[PW'(cur)].data_gnt = 1'b1;
      if (rv && q.size() > 0) begin
        exp_o[PW'(q[0])].data_rvalid = 1'b1;
        exp_o[PW'(q[0])].data_rdata  = rd;
      end
      exp_busy = m_locked || (q.size() != 0);

      n_checks++;
      if (bus_if.dcache_req_o !== exp_d) begin
        n_fail++;
        $display("FAIL rand_fwd[%0d]: got %h expected %h", n, bus_if.dcache_req_o, exp_d);
      end
      n_checks++;
      if (bus_if.req_ports_o !== exp_o) begin
        n_fail++;
        $display("FAIL rand_ports_o[%0d]: got %h expected %h", n, bus_if.req_ports_o, exp_o);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rand_busy[%0d]: got %b expected %b", n, busy, exp_busy);
      end

      if (rv && q.size() > 0) void'(q.pop_front());
      if (granted) begin
        if (!drv[cur].data_we) q.push_back(cur);
        m_rr = cur;
        m_locked = 1'b0;
        pending[cur] = 1'b0;
      end else if (!m_locked && cur_vld) begin
        m_locked = 1'b1;
        m_sel = cur;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_rr_order();
    test_lock_hold();
    test_fifo_full();
    test_same_cycle_push_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
